// File: rtl/logic_op_sweeper_if.sv
// Bus between the logic-op sweeper, its requester/consumer and the 2-input logic unit.
// `err` exists only when LOGIC_OP_SWEEPER_CHECK_EN is defined.
interface logic_op_sweeper_if;
  localparam int unsigned CHAVE_W = 2;
  localparam int unsigned VEC_W   = 4;

  logic               start;
  logic               a_in;
  logic               b_in;
  logic               result;
  logic               a;
  logic               b;
  logic [CHAVE_W-1:0] chave;
  logic               busy;
  logic               res_valid;
  logic               res_ready;
  logic [VEC_W-1:0]   res_vec;
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
  logic               err;

  modport master (output start, a_in, b_in, result, res_ready,
                  input  a, b, chave, busy, res_valid, res_vec, err);
  modport slave  (input  start, a_in, b_in, result, res_ready,
                  output a, b, chave, busy, res_valid, res_vec, err);
`else
  modport master (output start, a_in, b_in, result, res_ready,
                  input  a, b, chave, busy, res_valid, res_vec);
  modport slave  (input  start, a_in, b_in, result, res_ready,
                  output a, b, chave, busy, res_valid, res_vec);
`endif
endinterface

// File: rtl/logic_op_sweeper.sv
// Drives a latched operand pair through OR/NOR/XOR/XNOR and collects the 4-bit truth vector.
// Optional self-check of the collected vector: define LOGIC_OP_SWEEPER_CHECK_EN.
module logic_op_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  logic_op_sweeper_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             a_q;
  logic             b_q;
  logic [1:0]       chave_q;
  logic             busy_q;
  logic             valid_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] vec_upd_c;

  // Result vector with the current operation's sample merged in.
  always_comb begin
    vec_upd_c          = vec_q;
    vec_upd_c[chave_q] = bus.result;
  end

`ifdef LOGIC_OP_SWEEPER_CHECK_EN
  logic             err_q;
  logic [VEC_W-1:0] expected_c;

  assign expected_c = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), a_q | b_q};
  assign bus.err    = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      chave_q <= 2'b00;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      vec_q   <= '0;
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            chave_q <= 2'b00;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= SWEEP;
          end
        end
        SWEEP: begin
          // Sample only on the last settle cycle of each operation.
          if (cnt == CNT_LAST) begin
            vec_q <= vec_upd_c;
            cnt   <= '0;
            if (chave_q == 2'b11) begin
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              state   <= DONE;
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
              err_q   <= (vec_upd_c != expected_c);
`endif
            end else begin
              chave_q <= chave_q + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.chave     = chave_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_vec   = vec_q;

endmodule

// File: tb/tb_logic_op_sweeper.sv
// Bench for logic_op_sweeper: two instances (SETTLE=1 and SETTLE=3) against a timeline model.
// Build with LOGIC_OP_SWEEPER_CHECK_EN defined to also check `err`.
module tb_logic_op_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic_op_sweeper_if if1 ();
  logic_op_sweeper_if if3 ();

  logic_op_sweeper #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  logic_op_sweeper #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Per-instance stimulus (index 0 -> SETTLE=1, index 1 -> SETTLE=3).
  logic [1:0] st, ai, bi, rr, f0;

  function automatic logic unit_op(input logic x, input logic y, input logic [1:0] c);
    case (c)
      2'b00:   return x | y;
      2'b01:   return ~(x | y);
      2'b10:   return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  function automatic logic [3:0] truth(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), x | y};
  endfunction

  function automatic int sof(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  assign if1.start     = st[0];
  assign if1.a_in      = ai[0];
  assign if1.b_in      = bi[0];
  assign if1.res_ready = rr[0];
  assign if1.result    = f0[0] ? 1'b0 : unit_op(if1.a, if1.b, if1.chave);
  assign if3.start     = st[1];
  assign if3.a_in      = ai[1];
  assign if3.b_in      = bi[1];
  assign if3.res_ready = rr[1];
  assign if3.result    = f0[1] ? 1'b0 : unit_op(if3.a, if3.b, if3.chave);

  logic [1:0]      o_a, o_b, o_busy, o_valid;
  logic [1:0][1:0] o_ch;
  logic [1:0][3:0] o_vec;
  assign o_a[0] = if1.a;          assign o_a[1] = if3.a;
  assign o_b[0] = if1.b;          assign o_b[1] = if3.b;
  assign o_busy[0] = if1.busy;    assign o_busy[1] = if3.busy;
  assign o_valid[0] = if1.res_valid; assign o_valid[1] = if3.res_valid;
  assign o_ch[0] = if1.chave;     assign o_ch[1] = if3.chave;
  assign o_vec[0] = if1.res_vec;  assign o_vec[1] = if3.res_vec;
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
  logic [1:0] o_err;
  assign o_err[0] = if1.err;      assign o_err[1] = if3.err;
`endif

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Timeline model: phase 0 idle, 1 sweeping (t cycles since start edge), 2 result held.
  int         m_ph[2];
  int         m_t[2];
  logic       m_a[2], m_b[2], m_busy[2], m_valid[2], m_err[2];
  logic [1:0] m_ch[2];
  logic [3:0] m_vec[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ph[i] <= 0; m_t[i] <= 0; m_a[i] <= 1'b0; m_b[i] <= 1'b0;
        m_busy[i] <= 1'b0; m_valid[i] <= 1'b0; m_err[i] <= 1'b0;
        m_ch[i] <= 2'b00; m_vec[i] <= 4'b0000;
      end else begin
        case (m_ph[i])
          0: if (st[i]) begin
            m_a[i] <= ai[i]; m_b[i] <= bi[i]; m_ch[i] <= 2'b00;
            m_t[i] <= 0; m_ph[i] <= 1; m_busy[i] <= 1'b1;
          end
          1: begin
            m_t[i] <= m_t[i] + 1;
            if (m_t[i] + 1 == 4 * sof(i)) begin
              m_ph[i] <= 2; m_busy[i] <= 1'b0; m_valid[i] <= 1'b1; m_ch[i] <= 2'b11;
              m_vec[i] <= f0[i] ? 4'b0000 : truth(m_a[i], m_b[i]);
              m_err[i] <= f0[i] ? (truth(m_a[i], m_b[i]) != 4'b0000) : 1'b0;
            end else begin
              m_ch[i] <= 2'((m_t[i] + 1) / sof(i));
            end
          end
          default: if (rr[i]) begin
            m_valid[i] <= 1'b0; m_err[i] <= 1'b0; m_ph[i] <= 0;
          end
        endcase
      end
    end
  end

  // Cycle compare; the partially filled vector is not meaningful mid-sweep.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("a", i, 32'(o_a[i]), 32'(m_a[i]));
        chk("b", i, 32'(o_b[i]), 32'(m_b[i]));
        chk("chave", i, 32'(o_ch[i]), 32'(m_ch[i]));
        chk("busy", i, 32'(o_busy[i]), 32'(m_busy[i]));
        chk("res_valid", i, 32'(o_valid[i]), 32'(m_valid[i]));
        if (m_ph[i] != 1) chk("res_vec", i, 32'(o_vec[i]), 32'(m_vec[i]));
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
        if (m_valid[i]) chk("err", i, 32'(o_err[i]), 32'(m_err[i]));
`endif
      end
    end
  end

  task automatic start_pulse(input int i, input logic av, input logic bv);
    @(negedge clk);
    ai[i] = av; bi[i] = bv; st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0; ai[i] = ~av; bi[i] = ~bv;
  endtask

  // Called at the negedge right after the start edge; returns edges until res_valid.
  task automatic wait_valid(input int i, output int k);
    k = 0;
    while (!o_valid[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("valid_timeout", i, 32'(o_valid[i]), 32'd1);
  endtask

  task automatic ack(input int i);
    @(negedge clk); rr[i] = 1'b1;
    @(negedge clk); rr[i] = 1'b0;
    chk("ack_valid_lit", i, 32'(o_valid[i]), 32'd0);
  endtask

  task automatic sweep(input int i, input logic av, input logic bv,
                       input int exp_lat, input logic [3:0] exp_vec);
    int k;
    start_pulse(i, av, bv);
    wait_valid(i, k);
    chk("latency_lit", i, 32'(k), 32'(exp_lat));
    chk("res_vec_lit", i, 32'(o_vec[i]), 32'(exp_vec));
  endtask

  initial begin
    int k;
    st = '0; ai = '0; bi = '0; rr = '0; f0 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy_lit", i, 32'(o_busy[i]), 32'd0);
      chk("rst_valid_lit", i, 32'(o_valid[i]), 32'd0);
      chk("rst_vec_lit", i, 32'(o_vec[i]), 32'd0);
      chk("rst_chave_lit", i, 32'(o_ch[i]), 32'd0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset mid-sweep while chave=10 on the SETTLE=3 instance.
    start_pulse(1, 1'b1, 1'b0);
    k = 0;
    while (o_ch[1] != 2'b10 && k < 20) begin @(negedge clk); k++; end
    chk("reach_chave10", 1, 32'(o_ch[1]), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_lit", 1, 32'(o_a[1]), 32'd0);
    chk("mid_rst_chave_lit", 1, 32'(o_ch[1]), 32'd0);
    chk("mid_rst_busy_lit", 1, 32'(o_busy[1]), 32'd0);
    chk("mid_rst_vec_lit", 1, 32'(o_vec[1]), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid_lit", 1, 32'(o_valid[1]), 32'd0);
    chk("post_rst_busy_lit", 1, 32'(o_busy[1]), 32'd0);

    // Basic sweeps on both settle lengths.
    sweep(0, 1'b1, 1'b0, 4, 4'b0101);
    ack(0);
    sweep(1, 1'b1, 1'b1, 12, 4'b1001);
    ack(1);
    sweep(1, 1'b0, 1'b0, 12, 4'b1010);
    ack(1);

    // Backpressure in DONE with start pulsed, then ready and start together.
    sweep(0, 1'b0, 1'b1, 4, 4'b0101);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      st[0] = c[0];
      chk("bp_valid_lit", 0, 32'(o_valid[0]), 32'd1);
      chk("bp_vec_lit", 0, 32'(o_vec[0]), 32'h5);
    end
    @(negedge clk); rr[0] = 1'b1; st[0] = 1'b1;
    @(negedge clk); rr[0] = 1'b0; st[0] = 1'b0;
    chk("bp_exit_valid_lit", 0, 32'(o_valid[0]), 32'd0);
    chk("bp_exit_busy_lit", 0, 32'(o_busy[0]), 32'd0);
    @(negedge clk);
    chk("bp_no_sweep_lit", 0, 32'(o_busy[0]), 32'd0);

    // start held through a sweep: one sweep, then a new one right after release.
    @(negedge clk); ai[1] = 1'b1; bi[1] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    wait_valid(1, k);
    chk("held_latency_lit", 1, 32'(k), 32'd12);
    chk("held_vec_lit", 1, 32'(o_vec[1]), 32'h9);
    ai[1] = 1'b0; bi[1] = 1'b1;
    @(negedge clk); rr[1] = 1'b1;
    @(negedge clk); rr[1] = 1'b0;
    chk("held_idle_busy_lit", 1, 32'(o_busy[1]), 32'd0);
    @(negedge clk);
    st[1] = 1'b0;
    chk("held_restart_busy_lit", 1, 32'(o_busy[1]), 32'd1);
    chk("held_restart_a_lit", 1, 32'(o_a[1]), 32'd0);
    chk("held_restart_b_lit", 1, 32'(o_b[1]), 32'd1);
    wait_valid(1, k);
    chk("held2_vec_lit", 1, 32'(o_vec[1]), 32'h5);
    ack(1);

    // Broken logic unit (result stuck 0), then ideal again.
    f0[0] = 1'b1;
    sweep(0, 1'b1, 1'b0, 4, 4'b0000);
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
    chk("err_stuck_lit", 0, 32'(o_err[0]), 32'd1);
`endif
    ack(0);
    f0[0] = 1'b0;
    sweep(0, 1'b1, 1'b0, 4, 4'b0101);
`ifdef LOGIC_OP_SWEEPER_CHECK_EN
    chk("err_ideal_lit", 0, 32'(o_err[0]), 32'd0);
`endif
    ack(0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
